// File: rtl/line_derotator_if.sv
// Word stream and cut-position bundle between the descrambler front end and line_derotator.
interface line_derotator_if;
    logic [9:0] data_in;
    logic [7:0] raw_cut_position;
    logic       cut_valid;
    logic       H;
    logic       V;
    logic [9:0] data_out;
    logic       data_valid;
    logic       line_overflow;

    modport master (
        output data_in, raw_cut_position, cut_valid, H, V,
        input  data_out, data_valid, line_overflow
    );

    modport slave (
        input  data_in, raw_cut_position, cut_valid, H, V,
        output data_out, data_valid, line_overflow
    );
endinterface

// File: rtl/line_derotator.sv
// Receive-side inverse of the line rotation scrambler using a ping-pong line buffer.
// Define LINE_DEROTATOR_VBLANK_ROTATE_EN to derotate vertical blanking lines as well.
module line_derotator #(
    parameter int unsigned LINE_SIZE   = 1716,
    parameter int unsigned ACTIVE_SIZE = 1440,
    parameter int unsigned CUT_STEP    = 4
) (
    input logic             clk,
    input logic             reset_n,
    line_derotator_if.slave bus
);
    localparam int unsigned PW = $clog2(LINE_SIZE + 1);
    localparam int unsigned MW = $clog2(2 * LINE_SIZE);
    localparam int unsigned CW = $clog2(ACTIVE_SIZE);
    localparam int unsigned XW = $clog2(2 * ACTIVE_SIZE + LINE_SIZE);
    localparam logic [PW-1:0] LINE_P     = PW'(LINE_SIZE);
    localparam logic [XW-1:0] ACT_X      = XW'(ACTIVE_SIZE);
    localparam logic [MW-1:0] BANK1_BASE = MW'(LINE_SIZE);

    typedef enum logic [1:0] {WAIT_SYNC, FILL, RUN} state_e;

    state_e        state_q, state_d;
    logic          h_q;
    logic          bank_q;
    logic [PW-1:0] wr_pos_q, wr_pos_d;
    logic [PW-1:0] len_q [2];
    logic [CW-1:0] cut_q [2];
    logic          ovf_q, ovf_d;
    logic          ovf_done_q, ovf_done_d;
    logic          valid_q, valid_d;
    logic [9:0]    rd_data_q;
    logic [9:0]    mem_q [2*LINE_SIZE];

    logic          line_start, active;
    logic          wr_bank, rd_bank, wr_en;
    logic [PW-1:0] wr_addr, rd_len, rd_a;
    logic [XW-1:0] cut_prod, cut_new, rd_tmp;
    logic [CW-1:0] rd_cut;
    logic [MW-1:0] wr_idx, rd_idx;

    assign line_start = h_q & ~bus.H;
    assign active     = (state_q != WAIT_SYNC) | line_start;

    always_comb begin : cut_latch
        cut_prod = XW'(bus.raw_cut_position) * XW'(CUT_STEP);
        cut_new  = '0;
        if (bus.cut_valid) begin
            cut_new = (cut_prod >= ACT_X) ? cut_prod - ACT_X : cut_prod;
        end
`ifndef LINE_DEROTATOR_VBLANK_ROTATE_EN
        if (bus.V) begin
            cut_new = '0;
        end
`endif
    end

    always_comb begin : next_state
        state_d = state_q;
        if (line_start) begin
            case (state_q)
                WAIT_SYNC: state_d = FILL;
                FILL:      state_d = RUN;
                default:   state_d = state_q;
            endcase
        end
    end

    // The line-start word is written at address 0 of the freshly toggled bank.
    always_comb begin : write_side
        wr_addr    = line_start ? '0 : wr_pos_q;
        wr_bank    = line_start ? ~bank_q : bank_q;
        wr_en      = active && (wr_addr < LINE_P);
        wr_pos_d   = wr_pos_q;
        if (wr_en) begin
            wr_pos_d = wr_addr + 1'b1;
        end
        ovf_d      = active && !line_start && (wr_pos_q == LINE_P) && !ovf_done_q;
        ovf_done_d = line_start ? 1'b0 : (ovf_done_q | ovf_d);
        wr_idx     = wr_bank ? BANK1_BASE + MW'(wr_addr) : MW'(wr_addr);
    end

    // On the line-start cycle the finished line's length is still in wr_pos_q, so bypass it.
    always_comb begin : read_side
        rd_bank = ~wr_bank;
        rd_cut  = cut_q[rd_bank];
        rd_len  = line_start ? wr_pos_q : len_q[rd_bank];
        rd_tmp  = '0;
        rd_a    = '0;
        if (XW'(wr_addr) < ACT_X) begin
            rd_tmp = XW'(wr_addr) + ACT_X - XW'(rd_cut);
            if (rd_tmp >= ACT_X) begin
                rd_tmp = rd_tmp - ACT_X;
            end
            rd_a = PW'(rd_tmp);
        end else if (wr_addr < LINE_P) begin
            rd_a = wr_addr;
        end
        rd_idx  = rd_bank ? BANK1_BASE + MW'(rd_a) : MW'(rd_a);
        valid_d = ((state_q == RUN) || (state_q == FILL && line_start)) && (wr_addr < rd_len);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WAIT_SYNC;
            h_q        <= 1'b0;
            bank_q     <= 1'b0;
            wr_pos_q   <= '0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            cut_q[0]   <= '0;
            cut_q[1]   <= '0;
            ovf_q      <= 1'b0;
            ovf_done_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= bus.H;
            wr_pos_q   <= wr_pos_d;
            ovf_q      <= ovf_d;
            ovf_done_q <= ovf_done_d;
            valid_q    <= valid_d;
            if (line_start) begin
                bank_q          <= ~bank_q;
                len_q[bank_q]   <= wr_pos_q;
                cut_q[~bank_q]  <= CW'(cut_new);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= bus.data_in;
        end
        rd_data_q <= mem_q[rd_idx];
    end

    assign bus.data_out      = valid_q ? rd_data_q : '0;
    assign bus.data_valid    = valid_q;
    assign bus.line_overflow = ovf_q;
endmodule

// File: tb/tb_line_derotator.sv
// Scoreboard bench: scrambles known lines for CUT_STEP=4 and CUT_STEP=8 instances, expects originals back.
module tb_line_derotator;
    localparam int unsigned LS   = 1716;
    localparam int unsigned AS   = 1440;
    localparam int unsigned MAXL = 1800;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    line_derotator_if bus4();
    line_derotator_if bus8();

    line_derotator #(.LINE_SIZE(LS), .ACTIVE_SIZE(AS), .CUT_STEP(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );
    line_derotator #(.LINE_SIZE(LS), .ACTIVE_SIZE(AS), .CUT_STEP(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8)
    );

    typedef struct packed {
        logic       ovf;
        logic       valid;
        logic [9:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [9:0]  cur_orig [MAXL];
    logic [9:0]  prev_orig[MAXL];
    int unsigned cur_len   = 0;
    int unsigned prev_len  = 0;
    int unsigned line_no   = 0;
    bit          have_prev = 1'b0;
    bit          in_line   = 1'b0;

    task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned tx_cut(input int unsigned stp, input logic [7:0] raw,
                                           input logic cv, input logic v);
        if (!cv) return 0;
`ifndef LINE_DEROTATOR_VBLANK_ROTATE_EN
        if (v) return 0;
`endif
        return (int'(raw) * stp) % AS;
    endfunction

    task automatic step(input logic [9:0] d4, input logic [9:0] d8, input logic h, input logic v,
                        input logic cv, input logic [7:0] raw, input exp_t e);
        exp_t x;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check_eq($sformatf("out4 L%0d", line_no),
                     {bus4.line_overflow, bus4.data_valid, bus4.data_out}, x);
            check_eq($sformatf("out8 L%0d", line_no),
                     {bus8.line_overflow, bus8.data_valid, bus8.data_out}, x);
        end
        bus4.data_in = d4;  bus8.data_in = d8;
        bus4.H = h;         bus8.H = h;
        bus4.V = v;         bus8.V = v;
        bus4.cut_valid = cv;         bus8.cut_valid = cv;
        bus4.raw_cut_position = raw; bus8.raw_cut_position = raw;
        exp_q.push_back(e);
    endtask

    task automatic preamble(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step('0, '0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus4.H = 1'b1; bus8.H = 1'b1;
        bus4.data_in = '0; bus8.data_in = '0;
        exp_q.delete();
        #1;
        check_eq("rst4", {bus4.line_overflow, bus4.data_valid, bus4.data_out}, 12'h000);
        check_eq("rst8", {bus8.line_overflow, bus8.data_valid, bus8.data_out}, 12'h000);
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        have_prev = 1'b0;
        in_line   = 1'b0;
    endtask

    task automatic drive_line(input int unsigned len, input logic [7:0] raw, input logic cv,
                              input logic v, input bit ramp, input int unsigned abort_at);
        int unsigned c4, c8;
        exp_t        e;
        logic [9:0]  s4, s8;
        line_no++;
        if (in_line) begin
            prev_orig = cur_orig;
            prev_len  = (cur_len < LS) ? cur_len : LS;
            have_prev = 1'b1;
        end
        in_line = 1'b1;
        for (int unsigned k = 0; k < MAXL; k++) cur_orig[k] = ramp ? 10'(k) : 10'($urandom);
        cur_len = len;
        c4 = tx_cut(4, raw, cv, v);
        c8 = tx_cut(8, raw, cv, v);
        for (int unsigned p = 0; p < len; p++) begin
            if (abort_at != 0 && p == abort_at) begin
                do_reset();
                return;
            end
            s4 = (p < AS) ? cur_orig[(p + c4) % AS] : cur_orig[p];
            s8 = (p < AS) ? cur_orig[(p + c8) % AS] : cur_orig[p];
            e.valid = have_prev && (p < prev_len);
            e.data  = e.valid ? prev_orig[p] : 10'd0;
            e.ovf   = (p == LS);
            step(s4, s8, (p >= AS), v, cv, raw, e);
        end
    endtask

    initial begin
        bus4.data_in = '0; bus8.data_in = '0;
        bus4.H = 1'b1;     bus8.H = 1'b1;
        bus4.V = 1'b0;     bus8.V = 1'b0;
        bus4.cut_valid = 1'b0; bus8.cut_valid = 1'b0;
        bus4.raw_cut_position = '0; bus8.raw_cut_position = '0;
        do_reset();
        preamble(16);
        drive_line(LS,   8'd0,   1'b1, 1'b0, 1'b1, 0);
        drive_line(LS,   8'd10,  1'b1, 1'b0, 1'b1, 0);
        drive_line(LS,   8'd255, 1'b1, 1'b0, 1'b0, 0);
        drive_line(LS,   8'd200, 1'b1, 1'b0, 1'b0, 0);
        drive_line(LS,   8'd10,  1'b1, 1'b1, 1'b0, 0);
        drive_line(LS,   8'd77,  1'b0, 1'b0, 1'b0, 0);
        drive_line(1500, 8'd33,  1'b1, 1'b0, 1'b0, 0);
        drive_line(1800, 8'd99,  1'b1, 1'b0, 1'b0, 0);
        drive_line(LS,   8'd5,   1'b1, 1'b0, 1'b1, 0);
        drive_line(LS,   8'd128, 1'b1, 1'b0, 1'b0, 0);
        drive_line(LS,   8'd60,  1'b1, 1'b0, 1'b0, 700);
        preamble(16);
        drive_line(LS,   8'd10,  1'b1, 1'b0, 1'b0, 0);
        drive_line(LS,   8'd255, 1'b1, 1'b0, 1'b0, 0);
        drive_line(LS,   8'd1,   1'b1, 1'b0, 1'b0, 0);
        drive_line(LS,   8'd2,   1'b1, 1'b0, 1'b0, 0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
